// File: rtl/cabac_ctx_bank.sv
// CABAC context-model bank with a pipelined HEVC init engine
// and a single-slot shadow copy for entry-point save/restore.
module cabac_ctx_bank #(
  parameter int CTX_COUNT = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init_start,
  input  logic [5:0]       i_slice_qp,
  input  logic [1:0]       i_init_type,
  output logic [IDX_W+1:0] o_tbl_addr,
  output logic             o_tbl_rd,
  input  logic [7:0]       i_tbl_data,
  output logic             o_init_busy,
  output logic             o_init_done,
  input  logic [IDX_W-1:0] i_ctx_idx,
  output logic [6:0]       o_ctx_state,
  input  logic             i_upd_en,
  input  logic [6:0]       i_upd_state,
  input  logic             i_save,
  input  logic             i_restore,
  output logic             o_shadow_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDX_W:0]   CNT  = (IDX_W+1)'(CTX_COUNT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CTX_COUNT-1);

  state_t state, state_nxt;

  logic [IDX_W:0]   rd_cnt;
  logic [5:0]       qp;
  logic [1:0]       itype;
  logic             vld1, vld2, vld3;
  logic [IDX_W-1:0] idx1, idx2, idx3;
  logic signed [7:0]  m_in, n_in, m2, n2, n3;
  logic signed [12:0] m_x, q_x, prod, p3, n_x, sum;
  logic [7:0]       hi5;
  logic [6:0]       pre, init_state;
  logic             busy, rd, last_wr, act;
  logic             idx_ok, rest_ok, upd_ok, save_ok;

  logic [6:0] bank   [CTX_COUNT];
  logic [6:0] shadow [CTX_COUNT];

  assign busy    = (state == RUN);
  assign rd      = busy && (rd_cnt < CNT);
  assign last_wr = vld3 && (idx3 == LAST);
  assign act     = !busy && !i_init_start;
  assign idx_ok  = ({1'b0, i_ctx_idx} < CNT);
  assign rest_ok = act && i_restore && o_shadow_valid;
  assign upd_ok  = act && !rest_ok && i_upd_en && idx_ok;
  assign save_ok = act && !rest_ok && i_save;

  // initValue -> slope/offset, then product, then clipped state
  assign hi5  = {4'b0, i_tbl_data[7:4]} * 8'd5;
  assign m_in = $signed(hi5 - 8'd45);
  assign n_in = $signed({1'b0, i_tbl_data[3:0], 3'b000} - 8'd16);
  assign m_x  = {{5{m2[7]}}, m2};
  assign q_x  = {7'b0, qp};
  assign prod = m_x * q_x;
  assign n_x  = {{5{n3[7]}}, n3};
  assign sum  = (p3 >>> 4) + n_x;

  always_comb begin
    if (sum < 13'sd1)        pre = 7'd1;
    else if (sum > 13'sd126) pre = 7'd126;
    else                     pre = sum[6:0];
  end

  // pre<=63 maps to 63-pre (MPS 0), otherwise pre-64 (MPS 1)
  assign init_state = pre[6] ? {pre[5:0], 1'b1}
                             : {~pre[5:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_init_start) state_nxt = RUN;
      RUN:     if (!i_init_start && last_wr) state_nxt = DONE;
      DONE:    if (i_init_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_init_busy = busy;
    o_init_done = (state == DONE);
    o_tbl_rd    = rd;
    o_tbl_addr  = rd ? {itype, rd_cnt[IDX_W-1:0]} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      qp     <= '0;
      itype  <= '0;
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      vld3   <= 1'b0;
      idx1   <= '0;
      idx2   <= '0;
      idx3   <= '0;
      m2     <= '0;
      n2     <= '0;
      n3     <= '0;
      p3     <= '0;
    end else if (i_init_start) begin
      rd_cnt <= '0;
      qp     <= (i_slice_qp > 6'd51) ? 6'd51 : i_slice_qp;
      itype  <= (i_init_type == 2'd3) ? 2'd2 : i_init_type;
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      vld3   <= 1'b0;
    end else begin
      if (rd) rd_cnt <= rd_cnt + (IDX_W+1)'(1);
      vld1 <= rd;
      idx1 <= rd_cnt[IDX_W-1:0];
      vld2 <= vld1;
      idx2 <= idx1;
      m2   <= m_in;
      n2   <= n_in;
      vld3 <= vld2;
      idx3 <= idx2;
      p3   <= prod;
      n3   <= n2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            o_shadow_valid <= 1'b0;
    else if (i_init_start) o_shadow_valid <= 1'b0;
    else if (save_ok)      o_shadow_valid <= 1'b1;
  end

  // storage carries no reset; contents are meaningless until init
  always_ff @(posedge clk) begin
    if (vld3)         bank[idx3] <= init_state;
    else if (rest_ok) bank <= shadow;
    else if (upd_ok)  bank[i_ctx_idx] <= i_upd_state;
    if (save_ok) begin
      for (int k = 0; k < CTX_COUNT; k++) begin
        shadow[k] <= (upd_ok && i_ctx_idx == IDX_W'(k))
                   ? i_upd_state : bank[k];
      end
    end
  end

  assign o_ctx_state = idx_ok ? bank[i_ctx_idx] : '0;

endmodule

// File: tb/tb_cabac_ctx_bank.sv
// Scoreboard bench for cabac_ctx_bank: random ops against an
// arithmetic reference model, monitors pop expected responses.
module tb_cabac_ctx_bank;
  localparam int N  = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_init_start = 1'b0;
  logic [5:0]    i_slice_qp = '0;
  logic [1:0]    i_init_type = '0;
  logic [IW+1:0] o_tbl_addr;
  logic          o_tbl_rd;
  logic [7:0]    i_tbl_data = '0;
  logic          o_init_busy;
  logic          o_init_done;
  logic [IW-1:0] i_ctx_idx = '0;
  logic [6:0]    o_ctx_state;
  logic          i_upd_en = 1'b0;
  logic [6:0]    i_upd_state = '0;
  logic          i_save = 1'b0;
  logic          i_restore = 1'b0;
  logic          o_shadow_valid;

  cabac_ctx_bank #(.CTX_COUNT(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_init_start(i_init_start), .i_slice_qp(i_slice_qp),
    .i_init_type(i_init_type), .o_tbl_addr(o_tbl_addr),
    .o_tbl_rd(o_tbl_rd), .i_tbl_data(i_tbl_data),
    .o_init_busy(o_init_busy), .o_init_done(o_init_done),
    .i_ctx_idx(i_ctx_idx), .o_ctx_state(o_ctx_state),
    .i_upd_en(i_upd_en), .i_upd_state(i_upd_state),
    .i_save(i_save), .i_restore(i_restore),
    .o_shadow_valid(o_shadow_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [6:0] st;
    logic       shv;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0]    tbl [4][N];
  logic [6:0]    mb [N];
  logic [6:0]    ms [N];
  bit            mshv = 1'b0;
  exp_t          exp_q [$];
  logic [IW+1:0] addr_q [$];
  int            done_q [$];
  bit            probe = 1'b0;
  bit            rd_seen = 1'b0;
  logic [7:0]    rd_val = '0;
  bit            done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // external initValue table: data one cycle after the read strobe
  always @(negedge clk) begin
    rd_seen <= o_tbl_rd;
    rd_val  <= tbl[o_tbl_addr[IW+1:IW]][o_tbl_addr[IW-1:0]];
  end
  always @(posedge clk)
    i_tbl_data <= rd_seen ? rd_val : 8'($urandom);

  // monitor: table reads, done edge, context probes
  always @(negedge clk) begin
    logic [IW+1:0] a;
    exp_t e;
    int dc;
    if (o_tbl_rd) begin
      n_vec++;
      if (addr_q.size() == 0) begin
        n_bad++;
        $display("FAIL tbl_rd: read addr %h, expected no read", o_tbl_addr);
      end else begin
        a = addr_q.pop_front();
        if (o_tbl_addr !== a) begin
          n_bad++;
          $display("FAIL tbl_addr: got %h expected %h", o_tbl_addr, a);
        end
      end
    end
    if (o_init_done && !done_prev) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_rise: at cycle %0d, expected none", cyc);
      end else begin
        dc = done_q.pop_front();
        if (cyc != dc) begin
          n_bad++;
          $display("FAIL done_rise: cycle %0d expected %0d", cyc, dc);
        end
      end
    end
    done_prev = o_init_done;
    if (probe) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL probe: no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if (o_ctx_state !== e.st || o_shadow_valid !== e.shv) begin
          n_bad++;
          $display("FAIL ctx[%0d]: got %h/sv%b expected %h/sv%b",
                   e.idx, o_ctx_state, o_shadow_valid, e.st, e.shv);
        end
      end
    end
  end

  function automatic logic [6:0] ref_ctx(int v, int qp_in);
    int q, m, n, p, s, pre;
    q = (qp_in > 51) ? 51 : qp_in;
    m = (v / 16) * 5 - 45;
    n = (v % 16) * 8 - 16;
    p = m * q;
    s = (p >= 0) ? p / 16 : -((15 - p) / 16);
    s = s + n;
    pre = (s < 1) ? 1 : ((s > 126) ? 126 : s);
    if (pre < 64) return {6'(63 - pre), 1'b0};
    return {6'(pre - 64), 1'b1};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    i_init_start = 1'b0;
    i_upd_en = 1'b0;
    i_save = 1'b0;
    i_restore = 1'b0;
    probe = 1'b0;
  endtask

  task automatic peek(string nm, int idx, logic [6:0] e);
    i_ctx_idx = IW'(idx);
    #1;
    chk(nm, {25'b0, o_ctx_state}, {25'b0, e});
  endtask

  task automatic probe_ctx(int idx);
    i_ctx_idx = IW'(idx);
    probe = 1'b1;
    exp_q.push_back('{idx, (idx < N) ? mb[idx] : 7'h0, mshv});
    tick();
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) probe_ctx(k);
  endtask

  task automatic op(bit u, int idx, logic [6:0] st,
                    bit sv, bit rs, bit busy);
    i_ctx_idx = IW'(idx);
    i_upd_en = u;
    i_upd_state = st;
    i_save = sv;
    i_restore = rs;
    if (!busy) begin
      if (rs && mshv) mb = ms;
      else begin
        if (u && idx < N) mb[idx] = st;
        if (sv) begin
          ms = mb;
          mshv = 1'b1;
        end
      end
    end
    tick();
  endtask

  task automatic start(int qp_in, int ty);
    int te;
    te = (ty == 3) ? 2 : ty;
    i_slice_qp = 6'(qp_in);
    i_init_type = 2'(ty);
    i_init_start = 1'b1;
    done_q.delete();
    done_q.push_back(cyc + N + 4);
    mshv = 1'b0;
    tick();
    addr_q.delete();
    for (int k = 0; k < N; k++) begin
      addr_q.push_back({2'(te), IW'(k)});
      mb[k] = ref_ctx(int'(tbl[te][k]), qp_in);
    end
  endtask

  task automatic wait_done(bit junk);
    for (int c = 0; c < N + 20 && !o_init_done; c++) begin
      if (junk)
        op(1'b1, $urandom_range(0, N - 1), 7'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
      else
        tick();
    end
    chk("init_done_timeout", {31'b0, o_init_done}, 32'd1);
    chk("reads_outstanding", addr_q.size(), 32'd0);
  endtask

  initial begin
    for (int t = 0; t < 4; t++)
      for (int k = 0; k < N; k++) tbl[t][k] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, o_init_busy}, 32'd0);
    chk("rst_done", {31'b0, o_init_done}, 32'd0);
    chk("rst_shadow", {31'b0, o_shadow_valid}, 32'd0);
    chk("rst_tbl_rd", {31'b0, o_tbl_rd}, 32'd0);
    chk("rst_tbl_addr", {26'b0, o_tbl_addr}, 32'd0);
    rst_n = 1'b1;
    tick();

    tbl[0][0] = 8'd139;
    tbl[0][1] = 8'd154;
    start(26, 0);
    chk("busy_after_start", {31'b0, o_init_busy}, 32'd1);
    wait_done(1'b0);
    peek("t1_ctx0", 0, 7'h00);
    peek("t1_ctx1", 1, 7'h01);
    check_all();

    tbl[1][0] = 8'd0;
    tbl[1][1] = 8'd255;
    tbl[1][2] = 8'd63;
    start(51, 1);
    wait_done(1'b0);
    peek("qp51_lo", 0, 7'h7C);
    peek("qp51_hi", 1, 7'h7D);
    peek("qp51_63", 2, 7'h6E);
    check_all();
    start(60, 1);
    wait_done(1'b0);
    peek("qp60_lo", 0, 7'h7C);
    peek("qp60_hi", 1, 7'h7D);
    peek("qp60_63", 2, 7'h6E);
    check_all();

    start(20, 0);
    repeat (4) tick();
    start(33, 1);
    wait_done(1'b0);
    check_all();

    op(1'b1, 3, 7'h2A, 1'b0, 1'b0, 1'b0);
    op(1'b0, 0, 7'h00, 1'b1, 1'b0, 1'b0);
    op(1'b1, 3, 7'h10, 1'b0, 1'b0, 1'b0);
    probe_ctx(3);
    op(1'b0, 0, 7'h00, 1'b0, 1'b1, 1'b0);
    peek("restore_ctx3", 3, 7'h2A);
    chk("shadow_valid", {31'b0, o_shadow_valid}, 32'd1);

    op(1'b1, 2, 7'h55, 1'b1, 1'b0, 1'b0);
    op(1'b1, 2, 7'h00, 1'b0, 1'b0, 1'b0);
    probe_ctx(2);
    op(1'b0, 0, 7'h00, 1'b0, 1'b1, 1'b0);
    peek("save_upd_ctx2", 2, 7'h55);
    op(1'b1, 2, 7'h33, 1'b0, 1'b1, 1'b0);
    peek("restore_drops_upd", 2, 7'h55);
    op(1'b1, 4, 7'h11, 1'b0, 1'b0, 1'b0);
    op(1'b0, 0, 7'h00, 1'b1, 1'b1, 1'b0);
    check_all();

    start(40, 3);
    wait_done(1'b1);
    op(1'b0, 0, 7'h00, 1'b0, 1'b1, 1'b0);
    check_all();

    op(1'b1, 13, 7'h7F, 1'b0, 1'b0, 1'b0);
    probe_ctx(13);
    probe_ctx(15);
    check_all();

    repeat (300) begin
      if ($urandom_range(0, 2) == 0)
        probe_ctx($urandom_range(0, 15));
      else
        op($urandom_range(0, 1) == 1, $urandom_range(0, 15),
           7'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, 1'b0);
    end
    check_all();

    start(30, 0);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, o_init_busy}, 32'd0);
    chk("arst_tbl_rd", {31'b0, o_tbl_rd}, 32'd0);
    chk("arst_done", {31'b0, o_init_done}, 32'd0);
    addr_q.delete();
    done_q.delete();
    mshv = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_busy", {31'b0, o_init_busy}, 32'd0);
    chk("post_rst_done", {31'b0, o_init_done}, 32'd0);
    chk("post_rst_shadow", {31'b0, o_shadow_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cabac_ctx_bank.md
Name: cabac_ctx_bank

Overview:
- Parametrised CABAC context-model store with a pipelined initialisation engine. Generalises the fixed five-context decoder store to CTX_COUNT contexts.
- Initial values (HEVC 8-bit initValue) come from an external table port rather than a hard-coded case.
- Adds a single-slot shadow bank for WPP/entry-point context save and restore.
- Sits between the slice-header parser (QP, initType, start) and the bin decoder, which reads and updates one context per cycle.

Parameters:
- CTX_COUNT, 16, number of context models (2..64).
- IDX_W, 4, index width, ceil(log2(CTX_COUNT)), minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_init_start  in  1  pulse: (re)initialise all contexts.
- i_slice_qp  in  6  SliceQpY, sampled at i_init_start.
- i_init_type  in  2  initType 0..2, sampled at i_init_start.
- o_tbl_addr  out  IDX_W+2  table address {initType, ctxIdx}.
- o_tbl_rd  out  1  table read strobe.
- i_tbl_data  in  8  initValue, valid exactly 1 cycle after o_tbl_rd.
- o_init_busy  out  1  init in progress.
- o_init_done  out  1  contexts valid; low from reset/start until init completes.
- i_ctx_idx  in  IDX_W  context select for read/update.
- o_ctx_state  out  7  {pStateIdx[5:0], valMps}, combinational read of bank[i_ctx_idx].
- i_upd_en  in  1  write i_upd_state to bank[i_ctx_idx] at clock edge.
- i_upd_state  in  7  updated {pStateIdx, valMps}.
- i_save  in  1  pulse: copy whole bank to shadow.
- i_restore  in  1  pulse: copy shadow to bank.
- o_shadow_valid  out  1  shadow holds a saved set.

Behaviour:
- Reset (async, rst_n=0) values:
  - o_init_busy=0, o_init_done=0, o_shadow_valid=0, o_tbl_rd=0, o_tbl_addr=0.
  - Bank and shadow contents are don't-care.
- FSM has three states: IDLE, RUN, DONE.
  - i_init_start in any state goes to RUN. It latches qp, clipped to 51 if above 51, and initType. It sets read index to 0, o_init_busy=1, o_init_done=0, o_shadow_valid=0.
  - A start while RUN restarts from index 0 and flushes pipeline valid bits.
- RUN pipeline, one context per cycle:
  - S0: o_tbl_rd=1, o_tbl_addr={initType, idx}; idx increments.
  - S1: capture i_tbl_data. Derive m=(v>>4)*5-45 and n=((v&15)<<3)-16, both signed.
  - S2: registered product p = m*qp, 13-bit signed.
  - S3: s = (p>>>4)+n, arithmetic shift, 10-bit signed. pre = clip(1,126,s).
    - If pre<=63: valMps=0, pStateIdx=63-pre.
    - Else: valMps=1, pStateIdx=pre-64.
    - Write bank[k].
- o_tbl_rd is high for CTX_COUNT consecutive cycles.
- The last write occurs 3 cycles after the last read. The next cycle sets o_init_busy=0 and o_init_done=1 (state DONE).
- Start to done is CTX_COUNT+4 cycles.
- initType=3 is treated as 2.
- Read path: o_ctx_state is always combinational from the bank. There is no bypass: an update is visible on the cycle after i_upd_en.
- Priority per cycle is init activity > restore > save > update.
  - While busy, i_upd_en, i_save and i_restore are ignored.
  - Restore with o_shadow_valid=0 is ignored.
- Save in the same cycle as i_upd_en: the shadow captures the bank including that cycle's update. The bank is also updated.
- Restore in the same cycle as i_upd_en: the restore wins and the update is dropped.
- Save and restore in the same cycle: restore wins and the shadow is unchanged.
- i_ctx_idx >= CTX_COUNT: o_ctx_state=0 and the update is ignored.
- Reset mid-init: everything returns to reset values immediately, and no further table reads occur.

Test Plan:
- qp=26, initType=0, table returns 139 for ctx0 and 154 for ctx1 -> after done: ctx0=0x00 (m=-5, n=72, pre=63), ctx1=0x01 (pre=64). o_init_done rises at cycle CTX_COUNT+4 after start.
- qp=51, initValues 0 / 255 / 63 -> clips low to pre=1 giving 0x7C, clips high to pre=126 giving 0x7D, and 63 gives pre=8, 0x6E. qp=60 produces identical results to qp=51.
- Restart at cycle 5 of init with initType=1 -> o_tbl_addr restarts at {1,0}. Exactly CTX_COUNT reads follow the restart, and o_init_done stays low until the new sequence completes.
- After init: update ctx3=0x2A, save, update ctx3=0x10, restore -> o_ctx_state for ctx3 reads 0x2A. o_shadow_valid=1.
- Save with simultaneous i_upd_en ctx2=0x55, then update ctx2=0x00, then restore -> ctx2 reads 0x55. Restore with simultaneous update -> update dropped.
- Before any save, i_restore is ignored and the bank is unchanged. i_upd_en during busy is ignored. Async reset asserted mid-init -> o_init_busy and o_tbl_rd drop without waiting for a clock edge.
